// File: rtl/mac_sequencer.sv
// Sequences sum-of-products or Horner jobs onto the signed 8x8 MAC. Define MAC_SEQ_HORNER_EN to enable Horner mode.
// Drives one term every second cycle and returns the result 3 edges after the last operand; waits in DONE until res_ready.
module mac_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        mode,
    input  logic [3:0]  len,
    input  logic [7:0]  x_or_bias,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic [7:0]  op_a,
    input  logic [7:0]  op_b,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [16:0] res_data,
    output logic        busy,
    output logic [7:0]  mac_in_1,
    output logic [7:0]  mac_in_2,
    output logic [7:0]  mac_in_add,
    output logic        mac_mul_sel,
    output logic        mac_add_sel,
    input  logic [16:0] mac_result
);

    typedef enum logic [2:0] {S_IDLE, S_ACC, S_NEU, S_DRAIN, S_DONE} state_t;

    state_t      r_state, w_state_nxt;
    logic [3:0]  r_len, r_cnt, w_cnt_nxt;
    logic [7:0]  r_xb;
    logic [1:0]  r_drain, w_drain_nxt;
    logic [16:0] r_res_data, w_res_nxt;
    logic [7:0]  r_in_1, r_in_2, r_in_add, w_in_1, w_in_2, w_in_add;
    logic        r_add_sel, w_add_sel;
    logic        w_first;
`ifdef MAC_SEQ_HORNER_EN
    logic        r_mode, r_mul_sel, w_mul_sel;
`else
    logic        w_unused_mode;
    assign w_unused_mode = mode;
`endif

    assign w_first = (r_cnt == 4'd0);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_drain_nxt = r_drain;
        w_res_nxt   = r_res_data;
        // NEUTRAL drive: zero product plus the fed-back value
        w_in_1      = 8'd0;
        w_in_2      = 8'd0;
        w_in_add    = 8'd0;
        w_add_sel   = 1'b1;
`ifdef MAC_SEQ_HORNER_EN
        w_mul_sel   = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_ACC;
                    w_cnt_nxt   = 4'd0;
                end
            end
            S_ACC: begin
                if (op_valid) begin
`ifdef MAC_SEQ_HORNER_EN
                    if (r_mode) begin
                        w_in_add  = op_a;
                        w_add_sel = 1'b0;
                        if (!w_first) begin
                            w_in_2    = r_xb;
                            w_mul_sel = 1'b1;
                        end
                    end else begin
                        w_in_1    = op_a;
                        w_in_2    = op_b;
                        w_add_sel = !w_first;
                        w_in_add  = w_first ? r_xb : 8'd0;
                    end
`else
                    w_in_1    = op_a;
                    w_in_2    = op_b;
                    w_add_sel = !w_first;
                    w_in_add  = w_first ? r_xb : 8'd0;
`endif
                    if (r_cnt == r_len) begin
                        w_state_nxt = S_DRAIN;
                        w_drain_nxt = 2'd0;
                    end else begin
                        w_state_nxt = S_NEU;
                        w_cnt_nxt   = r_cnt + 4'd1;
                    end
                end else begin
                    // a stall still costs the full ACC/NEU pair to keep term parity
                    w_state_nxt = S_NEU;
                end
            end
            S_NEU: w_state_nxt = S_ACC;
            S_DRAIN: begin
                if (r_drain == 2'd2) begin
                    w_res_nxt   = mac_result;
                    w_state_nxt = S_DONE;
                end else begin
                    w_drain_nxt = r_drain + 2'd1;
                end
            end
            S_DONE: begin
                if (res_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_len      <= 4'd0;
            r_cnt      <= 4'd0;
            r_xb       <= 8'd0;
            r_drain    <= 2'd0;
            r_res_data <= 17'd0;
            r_in_1     <= 8'd0;
            r_in_2     <= 8'd0;
            r_in_add   <= 8'd0;
            r_add_sel  <= 1'b1;
`ifdef MAC_SEQ_HORNER_EN
            r_mode     <= 1'b0;
            r_mul_sel  <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_drain    <= w_drain_nxt;
            r_res_data <= w_res_nxt;
            r_in_1     <= w_in_1;
            r_in_2     <= w_in_2;
            r_in_add   <= w_in_add;
            r_add_sel  <= w_add_sel;
`ifdef MAC_SEQ_HORNER_EN
            r_mul_sel  <= w_mul_sel;
`endif
            if (r_state == S_IDLE && start) begin
                r_len  <= len;
                r_xb   <= x_or_bias;
`ifdef MAC_SEQ_HORNER_EN
                r_mode <= mode;
`endif
            end
        end
    end

    assign op_ready    = (r_state == S_ACC);
    assign res_valid   = (r_state == S_DONE);
    assign busy        = (r_state != S_IDLE);
    assign res_data    = r_res_data;
    assign mac_in_1    = r_in_1;
    assign mac_in_2    = r_in_2;
    assign mac_in_add  = r_in_add;
    assign mac_add_sel = r_add_sel;
`ifdef MAC_SEQ_HORNER_EN
    assign mac_mul_sel = r_mul_sel;
`else
    assign mac_mul_sel = 1'b0;
`endif

endmodule

// File: tb/tb_mac_sequencer.sv
// Directed bench for mac_sequencer with a behavioural two-register-loop MAC model.
module tb_mac_sequencer;

    logic        clk = 1'b0;
    logic        reset, start, mode, op_valid, op_ready, res_valid, res_ready, busy;
    logic [3:0]  len;
    logic [7:0]  x_or_bias, op_a, op_b, mac_in_1, mac_in_2, mac_in_add;
    logic        mac_mul_sel, mac_add_sel;
    logic [16:0] res_data, mac_result;

    int checks = 0;
    int errors = 0;
    logic [7:0] va [16];
    logic [7:0] vb [16];

    always #5 clk = ~clk;

    mac_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .len(len),
        .x_or_bias(x_or_bias), .op_valid(op_valid), .op_ready(op_ready),
        .op_a(op_a), .op_b(op_b), .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .busy(busy), .mac_in_1(mac_in_1), .mac_in_2(mac_in_2),
        .mac_in_add(mac_in_add), .mac_mul_sel(mac_mul_sel), .mac_add_sel(mac_add_sel),
        .mac_result(mac_result)
    );

    // MAC unit: r1 <= f(drive, r2); r2 <= r1; result taken from r2
    logic signed [16:0] m_r1, m_r2, m_prod_x, m_addend;
    logic signed [7:0]  m_mul_a;
    logic signed [15:0] m_prod;
    always_comb begin
        m_mul_a  = mac_mul_sel ? m_r2[7:0] : mac_in_1;
        m_prod   = m_mul_a * $signed(mac_in_2);
        m_prod_x = m_prod;
        m_addend = mac_add_sel ? m_r2 : 17'($signed(mac_in_add));
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_r1 <= '0;
            m_r2 <= '0;
        end else begin
            m_r1 <= m_prod_x + m_addend;
            m_r2 <= m_r1;
        end
    end
    assign mac_result = m_r2;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] outs_vec();
        return {3'b0, op_ready, res_valid, busy, mac_mul_sel, mac_add_sel,
                mac_in_1, mac_in_2, mac_in_add};
    endfunction

    task automatic run_job(input logic m, input logic [3:0] l, input logic [7:0] xb,
                           input int stall_at, input int stall_n, input int bp,
                           input logic [16:0] exp_res);
        int idx = 0;
        int cyc = 0;
        int stalled = 0;
        int since = 0;
        logic prev_hs = 1'b0;
        logic prev_rdy = 1'b0;
        logic hs;
        start = 1'b1; mode = m; len = l; x_or_bias = xb;
        @(negedge clk);
        start = 1'b0; mode = 1'b0;
        while (!res_valid && cyc < 400) begin
            chk("busy_run", busy, 1);
            chk("rdy_consec", prev_rdy & op_ready, 0);
            if (!prev_hs)
                chk("neutral", {mac_in_1, mac_in_2, mac_in_add, mac_mul_sel, mac_add_sel}, 26'h1);
            if (idx <= int'(l) && !(idx == stall_at && stalled < stall_n)) begin
                op_valid = 1'b1; op_a = va[idx]; op_b = vb[idx];
            end else begin
                op_valid = 1'b0;
                if (idx == stall_at) stalled++;
            end
            hs = op_valid & op_ready;
            prev_rdy = op_ready;
            @(posedge clk);
            since = hs ? 0 : since + 1;
            if (hs) idx++;
            prev_hs = hs;
            @(negedge clk);
            op_valid = 1'b0;
            cyc++;
        end
        chk("res_valid", res_valid, 1);
        chk("terms", idx, l + 1);
        chk("latency", since, 3);
        chk("res_data", res_data, exp_res);
        for (int i = 0; i < bp; i++) begin
            res_ready = 1'b0;
            start = (i == 0); mode = 1'b0; len = 4'd0;
            chk("bp_valid", res_valid, 1);
            chk("bp_hold", res_data, exp_res);
            chk("bp_busy", busy, 1);
            chk("bp_rdy", op_ready, 0);
            @(negedge clk);
        end
        start = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk("idle_valid", res_valid, 0);
        chk("idle_busy", busy, 0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; mode = 1'b0; len = 4'd0; x_or_bias = 8'd0;
        op_valid = 1'b0; op_a = 8'd0; op_b = 8'd0; res_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_outs", outs_vec(), 32'h0100_0000);
        chk("rst_res", res_data, 0);
        reset = 1'b0;
        @(negedge clk);

        va[0] = 8'd2; vb[0] = 8'd3;
        va[1] = 8'hFC; vb[1] = 8'd7;
        va[2] = 8'd10; vb[2] = 8'd10;
        run_job(1'b0, 4'd2, 8'd5, -1, 0, 0, 17'd83);
        run_job(1'b0, 4'd2, 8'd5, 1, 3, 0, 17'd83);

        va[0] = 8'd1; vb[0] = 8'd5;
        va[1] = 8'hFD; vb[1] = 8'd1;
        va[2] = 8'd4; vb[2] = 8'd2;
`ifdef MAC_SEQ_HORNER_EN
        run_job(1'b1, 4'd2, 8'd2, -1, 0, 5, 17'd2);
`else
        run_job(1'b1, 4'd2, 8'd2, -1, 0, 5, 17'd12);
`endif

        for (int i = 0; i < 5; i++) begin
            va[i] = 8'h80; vb[i] = 8'h80;
        end
        run_job(1'b0, 4'd4, 8'd0, -1, 0, 0, 17'h14000);

        // reset while the second term's ACC cycle is open
        start = 1'b1; mode = 1'b0; len = 4'd2; x_or_bias = 8'd5;
        @(negedge clk);
        start = 1'b0; op_valid = 1'b1; op_a = 8'd2; op_b = 8'd3;
        @(negedge clk);
        op_valid = 1'b0;
        @(negedge clk);
        chk("acc2_rdy", op_ready, 1);
        reset = 1'b1;
        #1;
        chk("midrst_outs", outs_vec(), 32'h0100_0000);
        chk("midrst_res", res_data, 0);
        @(negedge clk);
        chk("midrst_hold", outs_vec(), 32'h0100_0000);
        reset = 1'b0;
        @(negedge clk);
        va[0] = 8'd1; vb[0] = 8'd1;
        run_job(1'b0, 4'd0, 8'd0, -1, 0, 0, 17'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
